s820_resp_misr: RTL and testbench

//  Downstream response compactor for the s820 controller. Samples its 19 primary outputs every CK
//  for a programmed number of cycles, folds them into a multiple-input signature register (MISR),

---
 rtl/s820_resp_misr.sv | 83 ++++++++
 tb/tb_s820_resp_misr.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/s820_resp_misr.sv
// Response compactor for the s820 controller: folds RESP into a MISR for LEN cycles,
// then holds the signature on a valid/ready handshake until it is consumed or aborted.
module s820_resp_misr #(
  parameter int                RESP_W = 19,
  parameter int                SIG_W  = 24,
  parameter int                CNT_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = 24'hE10000,
  parameter logic [SIG_W-1:0]  SEED   = 24'h000000
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              START,
  input  logic [CNT_W-1:0]  LEN,
  input  logic              ABORT,
  input  logic [RESP_W-1:0] RESP,
  output logic [SIG_W-1:0]  SIG,
  output logic              SIG_VLD,
  input  logic              SIG_RDY,
  output logic              BUSY
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SIG_W-1:0] sig_n, step;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sig_n   = SIG;
    step    = {SIG[SIG_W-2:0], 1'b0} ^ (SIG[SIG_W-1] ? POLY : '0) ^ SIG_W'(RESP);
    case (state)
      IDLE: if (START) begin
        sig_n = SEED;
        if (LEN != '0) begin
          cnt_n   = LEN;
          state_n = RUN;
        end else begin
          state_n = HOLD;
        end
      end
      RUN: if (ABORT) begin
        // abort wins over the final step: the run never presents a signature
        state_n = IDLE;
        sig_n   = '0;
        cnt_n   = '0;
      end else begin
        sig_n = step;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = HOLD;
      end
      HOLD: if (ABORT) begin
        state_n = IDLE;
        sig_n   = '0;
        cnt_n   = '0;
      end else if (SIG_RDY) begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // flags are registered off the next state so they line up with state itself
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state   <= IDLE;
      cnt     <= '0;
      SIG     <= '0;
      SIG_VLD <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      SIG     <= sig_n;
      SIG_VLD <= (state_n == HOLD);
      BUSY    <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_s820_resp_misr.sv
// Scoreboard bench for s820_resp_misr: two instances (zero seed and MSB-set seed) share
// stimulus; expected signatures come from a reference step model and fixed known values.
module tb_s820_resp_misr;
  logic        CK, RN, START, ABORT, SIG_RDY;
  logic [15:0] LEN;
  logic [18:0] RESP;
  logic [23:0] a_sig, b_sig;
  logic        a_vld, b_vld, a_busy, b_busy;

  int checks, errors;
  logic [23:0] qa[$], qb[$];

  s820_resp_misr dut_a (
    .CK(CK), .RN(RN), .START(START), .LEN(LEN), .ABORT(ABORT), .RESP(RESP),
    .SIG(a_sig), .SIG_VLD(a_vld), .SIG_RDY(SIG_RDY), .BUSY(a_busy));

  s820_resp_misr #(.SEED(24'h800000)) dut_b (
    .CK(CK), .RN(RN), .START(START), .LEN(LEN), .ABORT(ABORT), .RESP(RESP),
    .SIG(b_sig), .SIG_VLD(b_vld), .SIG_RDY(SIG_RDY), .BUSY(b_busy));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mstep(input logic [23:0] s, input logic [18:0] r);
    logic [23:0] f;
    f = s[23] ? 24'hE10000 : 24'h0;
    return {s[22:0], 1'b0} ^ f ^ {5'h0, r};
  endfunction

  task automatic tick();
    @(posedge CK); #1;
  endtask

  // one full run through both instances; poke pulses START during RUN, HOLD and release
  task automatic do_run(input int len, input bit rnd, input logic [18:0] rv,
                        input bit poke, input int hold);
    logic [23:0] ea, eb, xa, xb;
    logic [18:0] r;
    int w;
    ea = 24'h0; eb = 24'h800000;
    xa = 24'h0; xb = 24'h0;
    START = 1'b1; LEN = 16'(len);
    if (len == 0) begin qa.push_back(ea); qb.push_back(eb); end
    tick();
    START = 1'b0;
    for (int i = 0; i < len; i++) begin
      r = rnd ? 19'($urandom) : rv;
      RESP  = r;
      START = poke && (i == 1);
      LEN   = 16'd1;
      ea = mstep(ea, r); eb = mstep(eb, r);
      if (i == len - 1) begin qa.push_back(ea); qb.push_back(eb); end
      tick();
    end
    START = 1'b0;
    RESP  = 19'($urandom);
    w = 0;
    while (!a_vld && w < 4) begin tick(); w++; end
    chk("vld_latency", w, 0);
    chk("vld_b", {31'h0, b_vld}, 1);
    if (qa.size() > 0) xa = qa.pop_front();
    if (qb.size() > 0) xb = qb.pop_front();
    chk("sig_a", a_sig, xa);
    chk("sig_b", b_sig, xb);
    SIG_RDY = 1'b0;
    for (int h = 0; h < hold; h++) begin
      START = poke && (h == 0);
      LEN   = 16'd3;
      RESP  = 19'($urandom);
      tick();
      chk("hold_vld", {31'h0, a_vld}, 1);
      chk("hold_sig", a_sig, xa);
    end
    SIG_RDY = 1'b1; START = poke;
    tick();
    SIG_RDY = 1'b0; START = 1'b0;
    chk("rel_vld", {31'h0, a_vld}, 0);
    chk("rel_busy", {31'h0, a_busy}, 0);
    chk("idle_sig", a_sig, xa);
    if (poke) begin
      tick();
      chk("no_restart", {31'h0, a_busy}, 0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    RN = 1'b0; START = 1'b0; LEN = 16'h0; ABORT = 1'b0; SIG_RDY = 1'b0; RESP = 19'h0;
    #1;
    chk("rst_sig", a_sig, 0);
    chk("rst_vld", {31'h0, a_vld}, 0);
    chk("rst_busy", {31'h0, a_busy}, 0);
    repeat (2) @(posedge CK);
    @(negedge CK); RN = 1'b1;
    tick();
    chk("post_rst_busy", {31'h0, a_busy}, 0);

    // asynchronous reset in the middle of a run
    START = 1'b1; LEN = 16'd20; tick(); START = 1'b0;
    for (int i = 0; i < 5; i++) begin RESP = 19'($urandom); tick(); end
    chk("run_busy", {31'h0, a_busy}, 1);
    #2 RN = 1'b0; #1;
    chk("async_sig", a_sig, 0);
    chk("async_vld", {31'h0, a_vld}, 0);
    chk("async_busy", {31'h0, a_busy}, 0);
    @(negedge CK); RN = 1'b1;
    tick();
    chk("async_idle", {31'h0, a_busy}, 0);

    // LEN=1, RESP=1
    do_run(1, 1'b0, 19'h1, 1'b0, 0);
    chk("len1_const", a_sig, 24'h000001);
    // LEN=2, RESP=1 twice, held 5 cycles
    do_run(2, 1'b0, 19'h1, 1'b0, 5);
    chk("len2_const", a_sig, 24'h000003);
    // feedback path: seed 800000, RESP=0
    do_run(1, 1'b0, 19'h0, 1'b0, 0);
    chk("fb_const", b_sig, 24'hE10000);
    // LEN=0 goes straight to HOLD with the seed; START pokes ignored everywhere
    do_run(0, 1'b0, 19'h0, 1'b1, 2);
    do_run(4, 1'b1, 19'h0, 1'b1, 2);
    for (int k = 0; k < 6; k++) do_run(int'($urandom_range(1, 12)), 1'b1, 19'h0, 1'b0, k % 3);
    do_run(30, 1'b1, 19'h0, 1'b0, 1);

    // abort at cycle 4 of a LEN=10 run
    START = 1'b1; LEN = 16'd10; tick(); START = 1'b0;
    for (int i = 0; i < 3; i++) begin RESP = 19'($urandom); tick(); end
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    chk("abort_busy", {31'h0, a_busy}, 0);
    chk("abort_sig", a_sig, 0);
    for (int i = 0; i < 8; i++) begin
      RESP = 19'($urandom); tick();
      chk("abort_novld", {31'h0, a_vld}, 0);
    end
    do_run(1, 1'b0, 19'h1, 1'b0, 0);
    chk("fresh_const", a_sig, 24'h000001);

    // abort beats the final RUN step
    START = 1'b1; LEN = 16'd2; tick(); START = 1'b0;
    RESP = 19'h7; tick();
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    chk("abort_last_vld", {31'h0, a_vld}, 0);
    chk("abort_last_sig", a_sig, 0);
    chk("abort_last_busy", {31'h0, a_busy}, 0);

    // abort beats SIG_RDY in HOLD
    START = 1'b1; LEN = 16'd0; tick(); START = 1'b0;
    chk("len0_vld", {31'h0, b_vld}, 1);
    chk("len0_seed", b_sig, 24'h800000);
    ABORT = 1'b1; SIG_RDY = 1'b1; tick(); ABORT = 1'b0; SIG_RDY = 1'b0;
    chk("abort_hold_sig", b_sig, 0);
    chk("abort_hold_vld", {31'h0, b_vld}, 0);

    // ABORT in IDLE is harmless
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    do_run(3, 1'b1, 19'h0, 1'b0, 0);
    chk("q_empty", qa.size() + qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
